// File: rtl/stack_data_memory_if.sv
// Memory-stage bus for stack_data_memory: decoded strobes in, read data and stack status out.
interface stack_data_memory_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 9
);
  logic                  store;
  logic                  load;
  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  rd_valid;
  logic [ADDR_WIDTH-1:0] sp;
  logic [ADDR_WIDTH:0]   stack_count;
  logic                  full;
  logic                  empty;
  logic                  err;

  modport master (
    output store, load, push, pop, address, data_in,
    input  data_out, rd_valid, sp, stack_count, full, empty, err
  );

  modport slave (
    input  store, load, push, pop, address, data_in,
    output data_out, rd_valid, sp, stack_count, full, empty, err
  );
endinterface

// File: rtl/stack_data_memory.sv
// Single-port data memory with a downward-growing hardware stack at the top of the
// address space; one operation per cycle, priority store > load > push > pop.
module stack_data_memory #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 9,
  parameter int STACK_DEPTH = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  stack_data_memory_if.slave  bus
);
  localparam int unsigned         DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] MAX_CNT = (ADDR_WIDTH+1)'(STACK_DEPTH);
  localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] A_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  rd_valid_q, err_q;
  logic [ADDR_WIDTH:0]   count_q;
  logic [ADDR_WIDTH-1:0] sp, sp_top;
  logic                  full, empty;
  logic                  do_store, do_load, do_push, do_pop;

  // count never exceeds STACK_DEPTH <= TOP, so the low bits alone give sp exactly
  assign sp     = {ADDR_WIDTH{1'b1}} - count_q[ADDR_WIDTH-1:0];
  assign sp_top = sp + A_ONE;
  assign full   = (count_q == MAX_CNT);
  assign empty  = (count_q == '0);

  assign do_store = bus.store;
  assign do_load  = !bus.store && bus.load;
  assign do_push  = !bus.store && !bus.load && bus.push;
  assign do_pop   = !bus.store && !bus.load && !bus.push && bus.pop;

  // Memory array is intentionally not reset.
  always_ff @(posedge clk) begin
    if (do_store)
      mem[bus.address] <= bus.data_in;
    else if (do_push && !full)
      mem[sp] <= bus.data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
      count_q    <= '0;
    end else begin
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
      if (do_load) begin
        data_out_q <= mem[bus.address];
        rd_valid_q <= 1'b1;
      end else if (do_push) begin
        if (full) err_q   <= 1'b1;
        else      count_q <= count_q + CNT_ONE;
      end else if (do_pop) begin
        if (empty) begin
          err_q <= 1'b1;
        end else begin
          data_out_q <= mem[sp_top];
          rd_valid_q <= 1'b1;
          count_q    <= count_q - CNT_ONE;
        end
      end
    end
  end

  assign bus.data_out    = data_out_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.err         = err_q;
  assign bus.stack_count = count_q;
  assign bus.sp          = sp;
  assign bus.full        = full;
  assign bus.empty       = empty;
endmodule

// File: tb/tb_stack_data_memory.sv
// Directed bench: stimulus queues expected read/err events, a negedge monitor checks them.
module tb_stack_data_memory;
  logic clk, rst_n;
  int   total = 0;
  int   bad   = 0;

  typedef struct {
    logic        rd;
    logic        er;
    logic [15:0] d;
  } ev_t;
  ev_t exp_q[$];
  logic [15:0] last;

  stack_data_memory_if #(.DATA_WIDTH(16), .ADDR_WIDTH(9)) bus ();

  stack_data_memory #(.DATA_WIDTH(16), .ADDR_WIDTH(9), .STACK_DEPTH(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input logic rd, input logic er, input logic [15:0] d);
    ev_t e;
    e.rd = rd; e.er = er; e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic op(input logic s, input logic l, input logic pu, input logic po,
                    input logic [8:0] a, input logic [15:0] d);
    bus.store = s; bus.load = l; bus.push = pu; bus.pop = po;
    bus.address = a; bus.data_in = d;
    @(posedge clk); #1;
    bus.store = 0; bus.load = 0; bus.push = 0; bus.pop = 0;
  endtask

  // Monitor: every read or error pulse must match the oldest expected event.
  always @(negedge clk) begin
    if (rst_n && (bus.rd_valid === 1'b1 || bus.err === 1'b1)) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event: rd_valid=%b err=%b data=%h", bus.rd_valid, bus.err, bus.data_out);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        if ({bus.rd_valid, bus.err} !== {e.rd, e.er} || bus.data_out !== e.d) begin
          bad++;
          $display("FAIL event: got rd=%b err=%b data=%h expected rd=%b err=%b data=%h",
                   bus.rd_valid, bus.err, bus.data_out, e.rd, e.er, e.d);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    bus.store = 0; bus.load = 0; bus.push = 0; bus.pop = 0;
    bus.address = '0; bus.data_in = '0;
    #2;
    chk("reset_data_out", 32'(bus.data_out), 32'h0);
    chk("reset_rd_valid", 32'(bus.rd_valid), 32'h0);
    chk("reset_err",      32'(bus.err), 32'h0);
    chk("reset_count",    32'(bus.stack_count), 32'd0);
    chk("reset_sp",       32'(bus.sp), 32'd511);
    chk("reset_empty",    32'(bus.empty), 32'h1);
    chk("reset_full",     32'(bus.full), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // store then load
    op(1, 0, 0, 0, 9'h010, 16'hA5A5);
    chk("store_no_rd", 32'(bus.rd_valid), 32'h0);
    expect_ev(1, 0, 16'hA5A5);
    op(0, 1, 0, 0, 9'h010, 16'h0);
    chk("load_data", 32'(bus.data_out), 32'hA5A5);
    chk("load_sp",   32'(bus.sp), 32'd511);
    op(0, 0, 0, 0, 9'h0, 16'h0);
    chk("rd_valid_pulse", 32'(bus.rd_valid), 32'h0);
    chk("hold_data", 32'(bus.data_out), 32'hA5A5);

    // three pushes, three pops
    op(0, 0, 1, 0, 9'h0, 16'h1111);
    op(0, 0, 1, 0, 9'h0, 16'h2222);
    op(0, 0, 1, 0, 9'h0, 16'h3333);
    chk("push3_sp",    32'(bus.sp), 32'd508);
    chk("push3_count", 32'(bus.stack_count), 32'd3);
    expect_ev(1, 0, 16'h3333); op(0, 0, 0, 1, 9'h0, 16'h0);
    expect_ev(1, 0, 16'h2222); op(0, 0, 0, 1, 9'h0, 16'h0);
    expect_ev(1, 0, 16'h1111); op(0, 0, 0, 1, 9'h0, 16'h0);
    chk("pop3_empty", 32'(bus.empty), 32'h1);
    chk("pop3_sp",    32'(bus.sp), 32'd511);

    // fill to capacity, overflow, drain, underflow
    op(1, 0, 0, 0, 9'd447, 16'h7777);
    for (int i = 0; i < 64; i++) op(0, 0, 1, 0, 9'h0, 16'h4000 + 16'(i));
    chk("full_flag",  32'(bus.full), 32'h1);
    chk("full_sp",    32'(bus.sp), 32'd447);
    chk("full_count", 32'(bus.stack_count), 32'd64);
    expect_ev(0, 1, 16'h1111);
    op(0, 0, 1, 0, 9'h0, 16'hDEAD);
    chk("ovf_count", 32'(bus.stack_count), 32'd64);
    expect_ev(1, 0, 16'h7777);
    op(0, 1, 0, 0, 9'd447, 16'h0);
    chk("ovf_mem447", 32'(bus.data_out), 32'h7777);
    for (int i = 63; i >= 0; i--) begin
      expect_ev(1, 0, 16'h4000 + 16'(i));
      op(0, 0, 0, 1, 9'h0, 16'h0);
    end
    last = 16'h4000;
    expect_ev(0, 1, last);
    op(0, 0, 0, 1, 9'h0, 16'h0);
    chk("udf_rd_valid", 32'(bus.rd_valid), 32'h0);
    chk("udf_hold",     32'(bus.data_out), 32'(last));
    chk("udf_count",    32'(bus.stack_count), 32'd0);

    // priority: store beats push, load beats pop
    op(0, 0, 1, 0, 9'h0, 16'h1234);
    op(1, 0, 1, 0, 9'h020, 16'hBEEF);
    chk("st_push_count", 32'(bus.stack_count), 32'd1);
    chk("st_push_err",   32'(bus.err), 32'h0);
    expect_ev(1, 0, 16'hBEEF);
    op(0, 1, 0, 1, 9'h020, 16'h0);
    chk("ld_pop_count", 32'(bus.stack_count), 32'd1);
    expect_ev(1, 0, 16'h1234);
    op(0, 0, 0, 1, 9'h0, 16'h0);
    chk("prio_empty", 32'(bus.empty), 32'h1);

    // reset mid-stack-use
    for (int i = 0; i < 5; i++) op(0, 0, 1, 0, 9'h0, 16'h5000 + 16'(i));
    chk("push5_sp", 32'(bus.sp), 32'd506);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_count", 32'(bus.stack_count), 32'd0);
    chk("midrst_data",  32'(bus.data_out), 32'h0);
    chk("midrst_empty", 32'(bus.empty), 32'h1);
    @(negedge clk); rst_n = 1'b1;
    expect_ev(0, 1, 16'h0);
    op(0, 0, 0, 1, 9'h0, 16'h0);
    chk("post_rst_empty", 32'(bus.empty), 32'h1);

    op(0, 0, 0, 0, 9'h0, 16'h0);
    op(0, 0, 0, 0, 9'h0, 16'h0);
    chk("events_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/stack_data_memory.md
# stack_data_memory

Parametrised single-port data memory with a built-in hardware stack, successor to the fixed 16-bit load/store/push/pop data memory. It owns the stack pointer internally, adds full/empty tracking, overflow/underflow error reporting and a read-valid strobe, and generalises data width, address width and stack depth. It sits in the CPU memory stage, driven by decoded store/load/push/pop strobes from the control unit.

## Interface
- DATA_WIDTH, 16, word width in bits.
- ADDR_WIDTH, 9, address width; memory depth is 2**ADDR_WIDTH words.
- STACK_DEPTH, 64, maximum stack entries; legal range 1 to 2**ADDR_WIDTH-1.

- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- store  in  1  write data_in to mem[address].
- load  in  1  read mem[address] into data_out.
- push  in  1  push data_in onto the stack.
- pop  in  1  pop the top of stack into data_out.
- address  in  ADDR_WIDTH  load/store word address.
- data_in  in  DATA_WIDTH  write data for store and push.
- data_out  out  DATA_WIDTH  registered read data.
- rd_valid  out  1  one-cycle pulse: data_out updated by load or pop this cycle.
- sp  out  ADDR_WIDTH  next free stack slot (TOP - count), TOP = 2**ADDR_WIDTH-1.
- stack_count  out  ADDR_WIDTH+1  number of stack entries.
- full  out  1  stack_count == STACK_DEPTH.
- empty  out  1  stack_count == 0.
- err  out  1  one-cycle pulse: push on full or pop on empty was rejected.

## Operation
- Stack occupies the top of memory and grows downward from TOP; region is [TOP-STACK_DEPTH+1, TOP]. No protection between load/store and the stack region; software partitions memory.
- One operation per cycle, fixed priority: store > load > push > pop. Lower-priority strobes asserted in the same cycle are ignored with no side effect and no err.
- store: mem[address] <= data_in. Outputs other than rd_valid=0 unchanged.
- load: data_out <= mem[address]; rd_valid=1.
- push (not full): mem[sp] <= data_in; stack_count += 1.
- push (full): memory and count unchanged; err=1.
- pop (not empty): data_out <= mem[sp+1]; stack_count -= 1; rd_valid=1.
- pop (empty): data_out and count unchanged; rd_valid=0; err=1.
- sp, full and empty are combinational from stack_count; sp = TOP - stack_count, never wraps given STACK_DEPTH limit.
- data_out holds its last value when no read occurs.
- Memory contents are not reset; they are undefined until written. Reads of unwritten words return X in simulation and are not checked.

## Timing
- Reset (rst_n low, asynchronous): data_out=0, rd_valid=0, err=0, stack_count=0 (so sp=TOP, empty=1, full=0). Memory untouched. Reset asserted mid-stack-use discards all entries.
- Inputs sampled at rising edge N; data_out, rd_valid, err, stack_count reflect the operation after edge N (one-cycle latency).
- rd_valid and err are single-cycle pulses, cleared every cycle in which no qualifying event occurs; back-to-back ops give back-to-back pulses.
- Push then pop on consecutive cycles returns the pushed word (write at edge N visible to read at edge N+1).
- Store to an address followed by load from it next cycle returns the stored word.
- Push at count STACK_DEPTH-1 sets full after that edge; the following push errs.

## Test plan
- Reset: hold rst_n low mid-cycle -> data_out=0, rd_valid=0, err=0, stack_count=0, sp=511, empty=1 immediately, without a clock edge.
- Store 0xA5A5 to address 0x010, load 0x010 next cycle -> data_out=0xA5A5, rd_valid pulse for one cycle, sp unchanged at 511.
- Push 0x1111, 0x2222, 0x3333 -> sp=508, count=3; three pops -> data_out 0x3333, 0x2222, 0x1111 with rd_valid each cycle, ending empty=1, sp=511.
- Push 64 words -> full=1, sp=447; 65th push -> err=1, count stays 64, mem[447] unchanged; pop on empty after draining -> err=1, data_out holds last popped value, rd_valid=0.
- Simultaneous store+push and load+pop -> only store (resp. load) takes effect, stack_count unchanged, err=0.
- Assert rst_n low after 5 pushes, release, pop -> err=1, empty=1, confirming count cleared.
